// File: rtl/disp_pkg.sv
// Shared digit codes, message codes and controller state encoding for the
// vending-machine seven-segment display.
package disp_pkg;

    localparam logic [3:0] DIG_BLANK = 4'hA;
    localparam logic [3:0] CH_E      = 4'hB;
    localparam logic [3:0] CH_R      = 4'hC;
    localparam logic [3:0] CH_D      = 4'hD;
    localparam logic [3:0] CH_O      = 4'hE;
    localparam logic [3:0] CH_N      = 4'hF;

    localparam logic [1:0] MSG_NONE  = 2'd0;
    localparam logic [1:0] MSG_DONE  = 2'd1;
    localparam logic [1:0] MSG_ERR   = 2'd2;
    localparam logic [1:0] MSG_NO    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STATUS,
        ST_MSG
    } state_t;

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as tick.
// Shared with the other scanners, so it carries no display knowledge.
module disp_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scanner and display arbiter: steps the active column every slot and
// chooses between the status view and a held vend message.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int MSG_HOLD = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sum,
    input  logic [2:0] candy_sum,
    input  logic       msg_req,
    input  logic [1:0] msg_code,
    input  logic       blank_en,
    output logic [3:0] data_out,
    output logic [7:0] display_column,
    output logic       msg_busy,
    output logic       frame_tick
);
    localparam int HW = $clog2(MSG_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MSG_HOLD);

    logic          tick;
    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic [1:0]    msg_reg, msg_next;
    logic [3:0]    data_reg, data_next;
    logic [7:0]    col_reg, col_next;
    logic          busy_reg, busy_next;
    logic          frame_reg, frame_next;
    logic [7:0]    col_sel;

    disp_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Code shown on digit idx for a given view; messages are right-justified.
    function automatic logic [3:0] digit_code(input state_t st, input logic [2:0] idx,
                                              input logic [3:0] s, input logic [2:0] c,
                                              input logic [1:0] m);
        logic [3:0] code;
        code = DIG_BLANK;
        if (st == ST_STATUS) begin
            case (idx)
                3'd0, 3'd1: code = 4'd0;
                3'd2:       code = (s > 4'd10) ? CH_E : ((s == 4'd10) ? 4'd0 : s);
                3'd3:       code = (s == 4'd10) ? 4'd1 : DIG_BLANK;
                3'd5:       code = {1'b0, c};
                default:    code = DIG_BLANK;
            endcase
        end else if (st == ST_MSG) begin
            case (m)
                MSG_DONE: begin
                    case (idx)
                        3'd3:    code = CH_D;
                        3'd2:    code = CH_O;
                        3'd1:    code = CH_N;
                        3'd0:    code = CH_E;
                        default: code = DIG_BLANK;
                    endcase
                end
                MSG_ERR: begin
                    case (idx)
                        3'd2:       code = CH_E;
                        3'd1, 3'd0: code = CH_R;
                        default:    code = DIG_BLANK;
                    endcase
                end
                MSG_NO: begin
                    case (idx)
                        3'd1:    code = CH_N;
                        3'd0:    code = CH_O;
                        default: code = DIG_BLANK;
                    endcase
                end
                default: code = DIG_BLANK;
            endcase
        end
        return code;
    endfunction

    for (genvar gi = 0; gi < 8; gi++) begin : g_col
        assign col_sel[gi] = (idx_next != 3'(gi));
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        hold_next  = hold_reg;
        msg_next   = msg_reg;
        data_next  = data_reg;
        col_next   = col_reg;
        frame_next = 1'b0;

        if (tick) begin
            idx_next = idx_reg + 3'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_STATUS;
                end
            end
            ST_STATUS, ST_MSG: begin
                // A fresh request beats a coincident frame countdown.
                if (msg_req && (msg_code != MSG_NONE)) begin
                    state_next = ST_MSG;
                    msg_next   = msg_code;
                    hold_next  = HOLD_LOAD;
                end else if ((state_reg == ST_MSG) && frame_reg) begin
                    hold_next = hold_reg - HW'(1);
                    if (hold_reg == HW'(1)) begin
                        state_next = ST_STATUS;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (tick) begin
            data_next  = digit_code(state_next, idx_next, sum, candy_sum, msg_next);
            col_next   = col_sel;
            frame_next = (idx_next == 3'd0);
        end
        // Blanking holds the column dark until the next slot boundary after release.
        if (blank_en) begin
            col_next = 8'hFF;
        end
        busy_next = (state_next == ST_MSG);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 3'd7;
            hold_reg  <= '0;
            msg_reg   <= MSG_NONE;
            data_reg  <= DIG_BLANK;
            col_reg   <= 8'hFF;
            busy_reg  <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            hold_reg  <= hold_next;
            msg_reg   <= msg_next;
            data_reg  <= data_next;
            col_reg   <= col_next;
            busy_reg  <= busy_next;
            frame_reg <= frame_next;
        end
    end

    assign data_out       = data_reg;
    assign display_column = col_reg;
    assign msg_busy       = busy_reg;
    assign frame_tick     = frame_reg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboarded bench: a slot/frame-level reference model queues the expected
// outputs every cycle and a negedge monitor compares them against the display.
module tb_disp_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int MSG_HOLD = 2;

    logic       clk;
    logic       reset_n;
    logic [3:0] sum;
    logic [2:0] candy_sum;
    logic       msg_req;
    logic [1:0] msg_code;
    logic       blank_en;
    logic [3:0] data_out;
    logic [7:0] display_column;
    logic       msg_busy;
    logic       frame_tick;

    disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .MSG_HOLD(MSG_HOLD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sum            (sum),
        .candy_sum      (candy_sum),
        .msg_req        (msg_req),
        .msg_code       (msg_code),
        .blank_en       (blank_en),
        .data_out       (data_out),
        .display_column (display_column),
        .msg_busy       (msg_busy),
        .frame_tick     (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [7:0] col;
        logic       busy;
        logic       frame;
        bit         slot;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Text on digit idx: the held message right-justified, else the status view.
    function automatic logic [3:0] exp_digit(bit on, int code, int idx, int s, int c);
        logic [31:0] txt;
        logic [3:0]  d2, d3;
        if (on) begin
            case (code)
                1:       txt = 32'hAAAA_DEFB;
                2:       txt = 32'hAAAA_ABCC;
                3:       txt = 32'hAAAA_AAFE;
                default: txt = 32'hAAAA_AAAA;
            endcase
        end else begin
            d2  = (s > 10) ? 4'hB : 4'(s % 10);
            d3  = (s == 10) ? 4'h1 : 4'hA;
            txt = {4'hA, 4'hA, 4'(c), 4'hA, d3, d2, 4'h0, 4'h0};
        end
        return txt[idx*4 +: 4];
    endfunction

    // Reference model, reasoning in edges since reset release.
    int         k;
    bit         msg_on;
    int         msg_c;
    int         left;
    bit         frame_prev;
    bit         dark;
    bit         have_slot;
    int         cur_idx;
    logic [3:0] shown;

    always @(posedge clk) begin
        exp_t e;
        bit   slot_edge;
        bit   frame_edge;
        bit   req_ok;
        if (!reset_n) begin
            k = 0; msg_on = 0; msg_c = 0; left = 0; frame_prev = 0;
            dark = 0; have_slot = 0; cur_idx = 7; shown = 4'hA;
            e.data = 4'hA; e.col = 8'hFF; e.busy = 0; e.frame = 0; e.slot = 0; e.idx = 7;
        end else begin
            k++;
            slot_edge = (k % SCAN_DIV == 0);
            if (slot_edge) cur_idx = ((k / SCAN_DIV) - 1) % 8;
            frame_edge = slot_edge && (cur_idx == 0);
            req_ok = msg_req && (msg_code != 2'd0) && (k > SCAN_DIV);
            if (req_ok) begin
                msg_on = 1; msg_c = int'(msg_code); left = MSG_HOLD;
            end else if (msg_on && frame_prev) begin
                left--;
                if (left == 0) msg_on = 0;
            end
            if (slot_edge) begin
                shown = exp_digit(msg_on, msg_c, cur_idx, int'(sum), int'(candy_sum));
                have_slot = 1;
            end
            dark = blank_en || (dark && !slot_edge);
            e.data  = shown;
            e.col   = (dark || !have_slot) ? 8'hFF : ~(8'h01 << cur_idx);
            e.busy  = msg_on;
            e.frame = frame_edge;
            e.slot  = slot_edge;
            e.idx   = cur_idx;
            frame_prev = frame_edge;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e.data || display_column !== e.col ||
                msg_busy !== e.busy || frame_tick !== e.frame) begin
                fails++;
                $display("FAIL scan t=%0t got data=%h col=%h busy=%b ft=%b want data=%h col=%h busy=%b ft=%b",
                         $time, data_out, display_column, msg_busy, frame_tick,
                         e.data, e.col, e.busy, e.frame);
            end else if (e.slot) begin
                $display("slot t=%0t idx=%0d col=%h data=%h busy=%b ft=%b",
                         $time, e.idx, display_column, data_out, msg_busy, frame_tick);
            end
        end
    end

    task automatic pulse_req(input logic [1:0] code);
        msg_req  = 1'b1;
        msg_code = code;
        @(negedge clk);
        msg_req  = 1'b0;
        msg_code = 2'd0;
    endtask

    task automatic wait_frame_in_msg(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (msg_on && frame_prev) begin
                ok = 1;
                return;
            end
        end
    endtask

    initial begin
        bit ok;
        reset_n = 1'b0; sum = 4'd0; candy_sum = 3'd0;
        msg_req = 1'b0; msg_code = 2'd0; blank_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Request during the first slot arrives in IDLE and must be ignored
        @(negedge clk);
        pulse_req(2'd3);
        sum = 4'd10; candy_sum = 3'd3;
        repeat (40) @(negedge clk);

        pulse_req(2'd1);
        repeat (100) @(negedge clk);

        // Reload coinciding with a frame pulse while a message is up
        pulse_req(2'd1);
        wait_frame_in_msg(ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL frame_wait got no frame pulse in MSG within 200 cycles, required one");
        end
        pulse_req(2'd2);
        repeat (90) @(negedge clk);

        blank_en = 1'b1;
        repeat (10) @(negedge clk);
        blank_en = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            sum       = 4'($urandom_range(0, 15));
            candy_sum = 3'($urandom_range(0, 7));
            msg_req   = ($urandom_range(0, 79) == 0);
            msg_code  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) blank_en = ~blank_en;
            @(negedge clk);
        end
        msg_req = 1'b0; msg_code = 2'd0; blank_en = 1'b0; sum = 4'd7; candy_sum = 3'd5;
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a message
        pulse_req(2'd3);
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 4'hA || display_column !== 8'hFF || msg_busy !== 1'b0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got data=%h col=%h busy=%b ft=%b want data=a col=ff busy=0 ft=0",
                     data_out, display_column, msg_busy, frame_tick);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);

        checks++;
        if (exp_q.size() > 1) begin
            fails++;
            $display("FAIL queue_depth got %0d pending, want at most 1", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
